// File: rtl/quad_input_conditioner_if.sv
// quad_input_conditioner_if: raw encoder pins, error clear and decoded strobes for one channel
interface quad_input_conditioner_if;
   logic quad_A, quad_B, quad_I, err_clear;
   logic direction, pulse, index, quad_error;
   modport master (output quad_A, quad_B, quad_I, err_clear, input direction, pulse, index, quad_error);
   modport slave (input quad_A, quad_B, quad_I, err_clear, output direction, pulse, index, quad_error);
endinterface

// File: rtl/quad_input_conditioner.sv
// quad_input_conditioner: synchronise, deglitch and 4x-decode one quadrature encoder channel
module quad_input_conditioner #(
   parameter int FILTER_LEN = 4,
   parameter int INDEX_GATE = 1
) (
   input logic clk,
   input logic reset,
   quad_input_conditioner_if.slave bus
);
   logic [2:0] raw, sync1, sync2, filt, filt_n;
   logic [2:0][3:0] cnt, cnt_n;
   logic [1:0] prev_ab, warm, chg;
   logic warming, i_prev, armed, legal, illegal, rise, arm_now, fire;
   assign raw = {bus.quad_I, bus.quad_B, bus.quad_A};
   assign warming = warm != 2'd2;
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         filt_n[i] = filt[i];
         cnt_n[i] = '0;
         if (warming) filt_n[i] = sync1[i];
         else if (sync2[i] != filt[i]) begin
            if (cnt[i] == 4'(FILTER_LEN - 1)) filt_n[i] = sync2[i];
            else cnt_n[i] = cnt[i] + 4'd1;
         end
      end
   end
   assign chg = {filt[0], filt[1]} ^ prev_ab;
   assign legal = !warming && (chg[1] ^ chg[0]);
   assign illegal = !warming && (&chg);
   assign rise = !warming && filt[2] && !i_prev;
   assign arm_now = armed || rise;
   assign fire = arm_now && filt[2] && (INDEX_GATE == 0 || (filt[0] && filt[1]));
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
         filt <= '0;
         cnt <= '0;
         warm <= '0;
         prev_ab <= '0;
         i_prev <= 1'b0;
         armed <= 1'b0;
         bus.pulse <= 1'b0;
         bus.direction <= 1'b0;
         bus.index <= 1'b0;
         bus.quad_error <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         filt <= filt_n;
         cnt <= cnt_n;
         warm <= warming ? warm + 2'd1 : warm;
         prev_ab <= warming ? {filt_n[0], filt_n[1]} : {filt[0], filt[1]};
         i_prev <= warming ? filt_n[2] : filt[2];
         armed <= arm_now && filt[2] && !fire;
         bus.pulse <= legal;
         bus.direction <= legal ? prev_ab[1] ^ filt[1] : bus.direction;
         bus.index <= fire;
         bus.quad_error <= illegal || (bus.quad_error && !bus.err_clear);
      end
   end
endmodule
